// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo PCM in 32-bit slots, one-entry input buffer,
// repeats the previous frame when no new pair is waiting at the frame boundary.
module audio_i2s_tx #(
    parameter int BCK_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data,
    output logic        frame_start,
    output logic        underrun
);
    localparam int               DIV_W    = $clog2(BCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_nxt;
    logic             pend_full;
    logic [15:0]      pend_left;
    logic [15:0]      pend_right;
    logic [15:0]      frame_left;
    logic [15:0]      frame_right;
    logic             div_wrap;
    logic             fall_evt;
    logic             frame_load;
    logic             accept;
    logic [4:0]       slot_nxt;
    logic [3:0]       bit_sel;
    logic [15:0]      word_nxt;
    logic             data_nxt;

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign fall_evt   = div_wrap & i2s_bck;
    assign frame_load = fall_evt & (bit_cnt == 6'd63);
    assign bit_nxt    = bit_cnt + 6'd1;
    assign in_ready   = ~pend_full & ~reset;
    assign accept     = in_valid & in_ready;

    // Serial bit for the slot being entered: slot 1 is the MSB, slot 16 the LSB.
    always_comb begin
        slot_nxt = bit_nxt[4:0];
        word_nxt = bit_nxt[5] ? frame_right : frame_left;
        bit_sel  = 4'(5'd16 - slot_nxt);
        data_nxt = 1'b0;
        if ((slot_nxt != 5'd0) && (slot_nxt <= 5'd16)) begin
            data_nxt = word_nxt[bit_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            i2s_bck <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            i2s_bck <= ~i2s_bck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // LRCK and DATA change together with the BCK fall, so they are stable at the rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            i2s_lrck <= 1'b0;
            i2s_data <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= bit_nxt[5];
            i2s_data <= data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full  <= 1'b0;
            pend_left  <= '0;
            pend_right <= '0;
        end else if (accept) begin
            pend_full  <= 1'b1;
            pend_left  <= left_in;
            pend_right <= right_in;
        end else if (frame_load) begin
            pend_full  <= 1'b0;
        end
    end

    // On underrun the frame registers are left alone, which repeats the last pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_left  <= '0;
            frame_right <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= frame_load;
            underrun    <= frame_load & ~pend_full;
            if (frame_load && pend_full) begin
                frame_left  <= pend_left;
                frame_right <= pend_right;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: BCK_DIV=8 and BCK_DIV=2 instances share stimulus, each
// checked every cycle against a slot-arithmetic model plus targeted scenario checks.
module tb_audio_i2s_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld;
    logic [15:0] lin;
    logic [15:0] rin;
    logic rdy8, bck8, lr8, d8, fs8, ur8;
    logic rdy2, bck2, lr2, d2, fs2, ur2;
    logic [5:0] outs [2];

    audio_i2s_tx #(.BCK_DIV(8)) dut8 (
        .clk(clk), .reset(rst), .left_in(lin), .right_in(rin), .in_valid(vld),
        .in_ready(rdy8), .i2s_bck(bck8), .i2s_lrck(lr8), .i2s_data(d8),
        .frame_start(fs8), .underrun(ur8)
    );

    audio_i2s_tx #(.BCK_DIV(2)) dut2 (
        .clk(clk), .reset(rst), .left_in(lin), .right_in(rin), .in_valid(vld),
        .in_ready(rdy2), .i2s_bck(bck2), .i2s_lrck(lr2), .i2s_data(d2),
        .frame_start(fs2), .underrun(ur2)
    );

    assign outs[0] = {rdy8, bck8, lr8, d8, fs8, ur8};
    assign outs[1] = {rdy2, bck2, lr2, d2, fs2, ur2};

    int n_checks = 0;
    int n_err    = 0;
    int t        = 0;
    int dv [2]   = '{8, 2};

    bit          pf [2];
    logic [15:0] pl [2];
    logic [15:0] pr [2];
    logic [15:0] cl [2];
    logic [15:0] cr [2];
    bit          acc [2];
    int          ur_cnt [2];
    int          ones_cnt [2];

    typedef struct {
        int         t;
        logic [4:0] exp;   // {bck, lrck, data, frame_start, underrun}
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        logic [15:0] w;
        int s;
        v = '0;
        for (int b = 0; b < 64; b++) begin
            s = b % 32;
            w = (b < 32) ? l : r;
            if (s >= 1 && s <= 16) v[63-b] = w[16-s];
        end
        return v;
    endfunction

    // Model: state follows from the edge count t since release and the sample history.
    task automatic model_step(input int i);
        int d, f, b, s;
        logic [15:0] w;
        logic efs, eur, a, ebck, edat;
        logic [5:0] e;
        d = dv[i];
        efs = 1'b0;
        eur = 1'b0;
        acc[i] = 1'b0;
        if (rst) begin
            pf[i] = 1'b0; pl[i] = '0; pr[i] = '0; cl[i] = '0; cr[i] = '0;
        end else begin
            a = vld && !pf[i];
            if (t % (128 * d) == 0) begin
                efs = 1'b1;
                if (pf[i]) begin
                    cl[i] = pl[i]; cr[i] = pr[i]; pf[i] = 1'b0;
                end else begin
                    eur = 1'b1;
                end
            end
            if (a) begin
                pf[i] = 1'b1; pl[i] = lin; pr[i] = rin; acc[i] = 1'b1;
            end
        end
        f = t / (2 * d);
        b = f % 64;
        s = b % 32;
        w = (b >= 32) ? cr[i] : cl[i];
        ebck = ((t / d) % 2) != 0;
        edat = (s >= 1 && s <= 16) ? w[16-s] : 1'b0;
        e = {(!rst && !pf[i]), ebck, (b >= 32), edat, efs, eur};
        n_checks++;
        if (outs[i] !== e) begin
            n_err++;
            $display("FAIL model_d%0d t=%0d: got %b expected %b", d, t, outs[i], e);
        end
        if (outs[i][2] === 1'b1) ones_cnt[i]++;
        if (outs[i][0] === 1'b1) ur_cnt[i]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) t = 0;
        else t = t + 1;
        for (int i = 0; i < 2; i++) model_step(i);
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (t < target && n < 5000) begin
            tick();
            n++;
        end
        if (t != target) chk("run_to_reached", 64'(t), 64'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        repeat (3) tick();
        chk("reset_outs_d8", 64'(outs[0]), 64'h0);
        chk("reset_outs_d2", 64'(outs[1]), 64'h0);
        rst = 1'b0;
        #1;
        chk("ready_on_release", 64'(rdy8), 64'h1);
        for (int i = 0; i < 2; i++) begin
            ur_cnt[i] = 0;
            ones_cnt[i] = 0;
        end
    endtask

    task automatic collect_frame(input int i, input int base, output logic [63:0] bits);
        int d;
        d = dv[i];
        bits = '0;
        for (int b = 0; b < 64; b++) begin
            run_to(base + 2 * d * b + d);
            bits[63-b] = outs[i][2];
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        int nfs, acc_in, rdy_cnt, k, n;

        rst = 1'b1; vld = 1'b0; lin = '0; rin = '0;
        tbl[0]  = '{1,    5'b00000};
        tbl[1]  = '{7,    5'b00000};
        tbl[2]  = '{8,    5'b10000};
        tbl[3]  = '{15,   5'b10000};
        tbl[4]  = '{16,   5'b00000};
        tbl[5]  = '{24,   5'b10000};
        tbl[6]  = '{511,  5'b10000};
        tbl[7]  = '{512,  5'b01000};
        tbl[8]  = '{1023, 5'b11000};
        tbl[9]  = '{1024, 5'b00011};
        tbl[10] = '{1025, 5'b00000};
        tbl[11] = '{1536, 5'b01000};
        tbl[12] = '{2048, 5'b00011};

        // Free-running timing against fixed checkpoints
        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].t);
            chk($sformatf("freerun_t%0d", tbl[i].t), 64'(outs[0][4:0]), 64'(tbl[i].exp));
        end
        chk("freerun_data_zero", 64'(ones_cnt[0]), 64'h0);

        // Single sample, then underrun repeats it
        do_reset();
        vld = 1'b1; lin = 16'h8001; rin = 16'h7FFE;
        tick();
        vld = 1'b0;
        chk("single_accept", 64'(acc[0]), 64'h1);
        collect_frame(1, 256, bits);
        chk("d2_frame_bits", bits, exp_frame(16'h8001, 16'h7FFE));
        run_to(1024);
        chk("first_load_frame_start", 64'(fs8), 64'h1);
        chk("first_load_no_underrun", 64'(ur8), 64'h0);
        collect_frame(0, 1024, bits);
        chk("d8_frame_bits", bits, exp_frame(16'h8001, 16'h7FFE));
        run_to(2048);
        chk("repeat_underrun", 64'(ur8), 64'h1);
        collect_frame(0, 2048, bits);
        chk("repeat_frame_bits", bits, exp_frame(16'h8001, 16'h7FFE));

        // Backpressure with an incrementing pair held valid
        do_reset();
        k = 0; vld = 1'b1; lin = 16'h1000; rin = 16'h2000;
        nfs = 0; acc_in = 0; rdy_cnt = 0; n = 0;
        while (nfs < 6 && n < 7000) begin
            tick();
            n++;
            if (fs8) begin
                if (nfs > 0) begin
                    chk("bp_accepts_per_frame", 64'(acc_in), 64'h1);
                    chk("bp_ready_cycles_per_frame", 64'(rdy_cnt), 64'h1);
                end
                acc_in = 0; rdy_cnt = 0; nfs++;
            end
            if (rdy8) rdy_cnt++;
            if (acc[0]) begin
                acc_in++; k++;
                lin = 16'(16'h1000 + k); rin = 16'(16'h2000 + k);
            end
        end
        vld = 1'b0;
        chk("bp_frames_seen", 64'(nfs), 64'h6);
        chk("bp_no_underrun", 64'(ur_cnt[0]), 64'h0);

        // Pending sample changed one clk before the load
        do_reset();
        vld = 1'b1; lin = 16'h1234; rin = 16'h5678;
        tick();
        vld = 1'b0;
        run_to(1023);
        chk("boundary_full_before_load", 64'(rdy8), 64'h0);
        vld = 1'b1; lin = 16'hAAAA; rin = 16'h5555;
        tick();
        chk("boundary_frame_start", 64'(fs8), 64'h1);
        chk("boundary_ready_reasserts", 64'(rdy8), 64'h1);
        tick();
        vld = 1'b0;
        chk("boundary_second_accept", 64'(acc[0]), 64'h1);
        chk("boundary_ready_drops", 64'(rdy8), 64'h0);
        collect_frame(0, 1024, bits);
        chk("boundary_frame_old", bits, exp_frame(16'h1234, 16'h5678));
        run_to(2048);
        chk("boundary_next_no_underrun", 64'(ur8), 64'h0);
        collect_frame(0, 2048, bits);
        chk("boundary_frame_new", bits, exp_frame(16'hAAAA, 16'h5555));

        // Reset pulse at right-channel slot 9 with a sample pending
        do_reset();
        vld = 1'b1; lin = 16'hFFFF; rin = 16'hFFFF;
        tick();
        vld = 1'b0;
        run_to(1024);
        vld = 1'b1; lin = 16'h0F0F; rin = 16'hF0F0;
        tick();
        vld = 1'b0;
        chk("midreset_pending_accept", 64'(acc[0]), 64'h1);
        run_to(1688);
        rst = 1'b1;
        tick();
        chk("midreset_outs", 64'(outs[0]), 64'h0);
        rst = 1'b0;
        ones_cnt[0] = 0; ur_cnt[0] = 0;
        run_to(2060);
        chk("midreset_no_stale_data", 64'(ones_cnt[0]), 64'h0);
        chk("midreset_underruns", 64'(ur_cnt[0]), 64'h2);

        // Random offers, checked cycle by cycle by the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            vld = ($urandom_range(0, 15) == 0);
            lin = 16'($urandom);
            rin = 16'($urandom);
            tick();
        end
        vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
